seg_capture: RTL and testbench
==============================

# seg_capture

Monitor-side capture block for the multiplexed active-low 7-segment display bus: it samples digit-select and segment lines as they are driven to the panel, debounces each digit, and decodes the segment patterns back to hex nibbles. It is the decode end of the hex-to-segment path and is used for on-board self-test and for loopback checking of the display driver. It is sequential: per-digit candidate registers, stability counters and committed outputs.

## Interface
- DIGITS, 8: number of multiplexed digits (1..8)
- STABLE, 4: consecutive identical samples required to commit a digit (2..15)
- clk  in  1  system clock; all logic on rising edge
- rst  in  1  synchronous reset, active-high
- an  in  DIGITS  digit select, active-low; a sample is legal only when exactly one bit is 0
- seg  in  8  segment lines, active-low (0 = lit), bit7 = a … bit1 = g, bit0 = dp
- hex  out  4*DIGITS  committed nibble per digit, digit k at [4k+3:4k]
- valid  out  DIGITS  digit k holds a decodable committed pattern
- blank  out  DIGITS  digit k committed as all-off (8'hFF)
- upd  out  1  one-cycle pulse: some digit's hex/valid/blank changed this cycle
- err  out  1  one-cycle pulse: a commit saw an undecodable pattern

## Operation
- Input stage: an and seg are registered once (an_q, seg_q) before any decision.
- Legal sample: an_q has exactly one 0 bit at index k. Illegal (all high, or several low) samples are ignored; no counter or output changes.
- Per digit k: cand[k] (8 bits), cnt[k] (4 bits, saturating at STABLE).
  - Legal sample for k with seg_q == cand[k]: cnt[k] += 1 if cnt[k] < STABLE.
  - Legal sample for k with seg_q != cand[k]: cand[k] <= seg_q, cnt[k] <= 1.
  - Samples for other digits leave digit k untouched (interleaving does not break a run).
- Commit: fires on the sample that takes cnt[k] from STABLE-1 to STABLE; exactly once per run. Further matching samples do not re-commit.
- Decode table (pattern -> nibble): 03->0, 9F->1, 25->2, 0D->3, 99->4, 49->5, 41->6, 1F->7, 01->8, 19->9, 11->A, 00->B, 63->C, 61->E, 71->F. Nibble D has no unique pattern and is never produced.
- Commit result:
  - In table: hex[k] <= nibble, valid[k] <= 1, blank[k] <= 0.
  - 8'hFF: blank[k] <= 1, valid[k] <= 0, hex[k] held.
  - Anything else: valid[k] <= 0, blank[k] <= 0, hex[k] held, err pulses.
- upd pulses only if the commit changes at least one of hex[k], valid[k], blank[k].
- Only one digit can commit per cycle (one-hot select), so no arbitration is needed.

## Timing
- Reset values: hex = 0, valid = 0, blank = 0, upd = 0, err = 0, cand[*] = 8'hFF, cnt[*] = 0, an_q = all ones, seg_q = 8'hFF.
- Latency: if matching legal samples for digit k are presented on an/seg at edges t … t+STABLE-1 (consecutive for k, possibly interleaved with other digits), outputs for k update at the edge one cycle after the last sample is registered. Fully back-to-back: first sample at edge t, outputs change at edge t+STABLE+1.
- upd/err are high for exactly the one cycle following the commit edge.
- Reset mid-run: all runs discarded; a new run needs a full STABLE samples after rst falls.
- A mismatch on the STABLE-th sample restarts the run at cnt = 1; no commit and no err.
- Held pattern identical to the committed one: cnt saturates, with no further upd.

## Structure
- Package seg_pkg: the 15 pattern constants plus SEG_BLANK = 8'hFF, and a decode-result type {ok, blank, nib[3:0]}.
- Sub-module seg_dec: combinational pattern -> {ok, blank, nib}, one instance on seg_q shared by all digits.
- Top: input registers, one-hot check, per-digit cand/cnt arrays (generate loop), and commit/output registers.

## Test plan
- Reset, then scan digits 0..7 with patterns 03,9F,25,0D,99,49,41,1F, each for 4 consecutive scan frames (one sample per digit per frame) -> hex = 32'h76543210, valid = 8'hFF, 8 upd pulses, err never high.
- Digit 2 with 25,25,25,9F,9F,9F,9F (STABLE = 4) -> single commit hex[2] = 1 at the 4th 9F; 25 is never committed.
- Digit 0 with 8'hFF ×4, then 8'h5A ×4 -> blank[0] = 1 then valid[0] = 0, blank[0] = 0, one err pulse, hex[0] unchanged.
- an = all ones and an = 8'hFC (two low) for 10 cycles each, with seg toggling -> no state change, no upd.
- Assert rst after 3 matching samples on digit 5, then 4 more samples -> commit only after the post-reset 4th sample; all outputs are 0 during reset.
- Re-commit an identical value (digit 1 steady at 9F for 20 samples) -> exactly one upd pulse.

Source files
------------

// File: rtl/seg_pkg.sv
// rtl/seg_pkg.sv - segment pattern constants and decode-result type
`timescale 1ns/1ps
package seg_pkg;

    localparam logic [7:0] SEG_0     = 8'h03;
    localparam logic [7:0] SEG_1     = 8'h9F;
    localparam logic [7:0] SEG_2     = 8'h25;
    localparam logic [7:0] SEG_3     = 8'h0D;
    localparam logic [7:0] SEG_4     = 8'h99;
    localparam logic [7:0] SEG_5     = 8'h49;
    localparam logic [7:0] SEG_6     = 8'h41;
    localparam logic [7:0] SEG_7     = 8'h1F;
    localparam logic [7:0] SEG_8     = 8'h01;
    localparam logic [7:0] SEG_9     = 8'h19;
    localparam logic [7:0] SEG_A     = 8'h11;
    localparam logic [7:0] SEG_B     = 8'h00;
    localparam logic [7:0] SEG_C     = 8'h63;
    localparam logic [7:0] SEG_E     = 8'h61;
    localparam logic [7:0] SEG_F     = 8'h71;
    localparam logic [7:0] SEG_BLANK = 8'hFF;

    typedef struct packed {
        logic       ok;
        logic       blank;
        logic [3:0] nib;
    } dec_t;

endpackage

// File: rtl/seg_capture_if.sv
// rtl/seg_capture_if.sv - display bus sampled by seg_capture plus its decoded outputs
`timescale 1ns/1ps
interface seg_capture_if #(
    parameter int DIGITS = 8
);
    logic [DIGITS-1:0]   an;
    logic [7:0]          seg;
    logic [4*DIGITS-1:0] hex;
    logic [DIGITS-1:0]   valid;
    logic [DIGITS-1:0]   blank;
    logic                upd;
    logic                err;

    modport master (output an, seg, input hex, valid, blank, upd, err);
    modport slave  (input an, seg, output hex, valid, blank, upd, err);
endinterface

// File: rtl/seg_dec.sv
// rtl/seg_dec.sv - combinational segment pattern to nibble decoder
`timescale 1ns/1ps
module seg_dec
    import seg_pkg::*;
(
    input  logic [7:0] pat,
    output dec_t       res
);

    always_comb begin
        res = '0;
        case (pat)
            SEG_0:     res = '{ok: 1'b1, blank: 1'b0, nib: 4'h0};
            SEG_1:     res = '{ok: 1'b1, blank: 1'b0, nib: 4'h1};
            SEG_2:     res = '{ok: 1'b1, blank: 1'b0, nib: 4'h2};
            SEG_3:     res = '{ok: 1'b1, blank: 1'b0, nib: 4'h3};
            SEG_4:     res = '{ok: 1'b1, blank: 1'b0, nib: 4'h4};
            SEG_5:     res = '{ok: 1'b1, blank: 1'b0, nib: 4'h5};
            SEG_6:     res = '{ok: 1'b1, blank: 1'b0, nib: 4'h6};
            SEG_7:     res = '{ok: 1'b1, blank: 1'b0, nib: 4'h7};
            SEG_8:     res = '{ok: 1'b1, blank: 1'b0, nib: 4'h8};
            SEG_9:     res = '{ok: 1'b1, blank: 1'b0, nib: 4'h9};
            SEG_A:     res = '{ok: 1'b1, blank: 1'b0, nib: 4'hA};
            SEG_B:     res = '{ok: 1'b1, blank: 1'b0, nib: 4'hB};
            SEG_C:     res = '{ok: 1'b1, blank: 1'b0, nib: 4'hC};
            SEG_E:     res = '{ok: 1'b1, blank: 1'b0, nib: 4'hE};
            SEG_F:     res = '{ok: 1'b1, blank: 1'b0, nib: 4'hF};
            SEG_BLANK: res = '{ok: 1'b0, blank: 1'b1, nib: 4'h0};
            default:   res = '0;
        endcase
    end

endmodule

// File: rtl/seg_capture.sv
// rtl/seg_capture.sv - samples the multiplexed 7-segment bus, debounces per digit, decodes to hex
`timescale 1ns/1ps
module seg_capture
    import seg_pkg::*;
#(
    parameter int DIGITS = 8,
    parameter int STABLE = 4
) (
    input  logic          clk,
    input  logic          rst,
    seg_capture_if.slave  bus
);

    localparam logic [3:0] STABLE_C = 4'(STABLE);

    logic [DIGITS-1:0]   an_q;
    logic [7:0]          seg_q;
    logic                legal;
    logic [DIGITS-1:0]   sel;
    logic [DIGITS-1:0]   commit;
    dec_t                dec;

    logic [4*DIGITS-1:0] nxt_hex;
    logic [DIGITS-1:0]   nxt_valid;
    logic [DIGITS-1:0]   nxt_blank;
    logic                nxt_upd;
    logic                nxt_err;

    always_ff @(posedge clk) begin
        if (rst) begin
            an_q  <= '1;
            seg_q <= SEG_BLANK;
        end else begin
            an_q  <= bus.an;
            seg_q <= bus.seg;
        end
    end

    // Ghosting or idle scans (zero or several digits selected) carry no usable digit.
    always_comb begin
        legal = ($countones(~an_q) == 1);
        sel   = legal ? ~an_q : '0;
    end

    seg_dec u_dec (
        .pat (seg_q),
        .res (dec)
    );

    for (genvar k = 0; k < DIGITS; k++) begin : g_digit
        logic [7:0] cand;
        logic [3:0] cnt;
        logic       match;

        assign match     = (seg_q == cand);
        assign commit[k] = sel[k] && match && (cnt == STABLE_C - 4'd1);

        always_ff @(posedge clk) begin
            if (rst) begin
                cand <= SEG_BLANK;
                cnt  <= '0;
            end else if (sel[k]) begin
                if (!match) begin
                    cand <= seg_q;
                    cnt  <= 4'd1;
                end else if (cnt < STABLE_C) begin
                    cnt <= cnt + 4'd1;
                end
            end
        end
    end

    // At most one commit bit is set, so the loop never merges two digits.
    always_comb begin
        nxt_hex   = bus.hex;
        nxt_valid = bus.valid;
        nxt_blank = bus.blank;
        for (int k = 0; k < DIGITS; k++) begin
            if (commit[k]) begin
                if (dec.ok) begin
                    nxt_hex[4*k +: 4] = dec.nib;
                    nxt_valid[k]      = 1'b1;
                    nxt_blank[k]      = 1'b0;
                end else begin
                    nxt_valid[k] = 1'b0;
                    nxt_blank[k] = dec.blank;
                end
            end
        end
        nxt_upd = (|commit) &&
                  ({nxt_hex, nxt_valid, nxt_blank} != {bus.hex, bus.valid, bus.blank});
        nxt_err = (|commit) && !dec.ok && !dec.blank;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bus.hex   <= '0;
            bus.valid <= '0;
            bus.blank <= '0;
            bus.upd   <= 1'b0;
            bus.err   <= 1'b0;
        end else begin
            bus.hex   <= nxt_hex;
            bus.valid <= nxt_valid;
            bus.blank <= nxt_blank;
            bus.upd   <= nxt_upd;
            bus.err   <= nxt_err;
        end
    end

endmodule

// File: tb/tb_seg_capture.sv
// tb/tb_seg_capture.sv - directed scoreboard bench for seg_capture
`timescale 1ns/1ps
module tb_seg_capture;

    localparam int DIGITS = 8;
    localparam int STABLE = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    seg_capture_if #(.DIGITS(DIGITS)) bus ();

    seg_capture #(.DIGITS(DIGITS), .STABLE(STABLE)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct packed {
        logic [31:0] hex;
        logic [7:0]  valid;
        logic [7:0]  blank;
    } snap_t;

    snap_t q[$];
    snap_t exp_s;
    snap_t mon_e;
    int    checks   = 0;
    int    failures = 0;
    int    upd_cnt  = 0;
    int    err_cnt  = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (bus.err === 1'b1) err_cnt++;
            if (bus.upd === 1'b1) begin
                upd_cnt++;
                if (q.size() == 0) begin
                    checks++;
                    failures++;
                    $error("FAIL upd_unexpected observed=1 expected=0");
                end else begin
                    mon_e = q.pop_front();
                    chk("upd_hex",   bus.hex,           mon_e.hex);
                    chk("upd_valid", 32'(bus.valid),    32'(mon_e.valid));
                    chk("upd_blank", 32'(bus.blank),    32'(mon_e.blank));
                end
            end
        end
    end

    task automatic smp(input int d, input logic [7:0] s);
        logic [7:0] one;
        one = 8'd1;
        @(negedge clk);
        bus.an  = ~(one << d);
        bus.seg = s;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            bus.an  = '1;
            bus.seg = 8'hFF;
        end
    endtask

    task automatic push(input int d, input logic [3:0] nib, input logic v, input logic b);
        if (v) exp_s.hex[4*d +: 4] = nib;
        exp_s.valid[d] = v;
        exp_s.blank[d] = b;
        q.push_back(exp_s);
    endtask

    task automatic drain();
        for (int i = 0; i < 20 && q.size() > 0; i++) idle(1);
        chk("drain_timeout", 32'(q.size()), 32'd0);
        idle(3);
    endtask

    logic [7:0] pat [8];

    initial begin
        pat = '{8'h03, 8'h9F, 8'h25, 8'h0D, 8'h99, 8'h49, 8'h41, 8'h1F};
        exp_s   = '0;
        bus.an  = '1;
        bus.seg = 8'hFF;
        rst     = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_hex",   bus.hex,         32'h0);
        chk("rst_valid", 32'(bus.valid),  32'h0);
        chk("rst_blank", 32'(bus.blank),  32'h0);
        chk("rst_upd",   32'(bus.upd),    32'h0);
        chk("rst_err",   32'(bus.err),    32'h0);
        rst = 1'b0;

        for (int f = 0; f < STABLE; f++) begin
            for (int d = 0; d < DIGITS; d++) begin
                if (f == STABLE - 1) push(d, 4'(d), 1'b1, 1'b0);
                smp(d, pat[d]);
            end
        end
        drain();
        chk("scan_hex",   bus.hex,        32'h76543210);
        chk("scan_valid", 32'(bus.valid), 32'hFF);
        chk("scan_upd",   32'(upd_cnt),   32'd8);
        chk("scan_err",   32'(err_cnt),   32'd0);

        repeat (3) smp(2, 8'h25);
        repeat (3) smp(2, 8'h9F);
        push(2, 4'h1, 1'b1, 1'b0);
        smp(2, 8'h9F);
        drain();
        chk("restart_hex", bus.hex,      32'h76543110);
        chk("restart_upd", 32'(upd_cnt), 32'd9);

        repeat (3) smp(0, 8'hFF);
        push(0, 4'h0, 1'b0, 1'b1);
        smp(0, 8'hFF);
        repeat (3) smp(0, 8'h5A);
        push(0, 4'h0, 1'b0, 1'b0);
        smp(0, 8'h5A);
        drain();
        chk("bad_hex",   bus.hex,        32'h76543110);
        chk("bad_valid", 32'(bus.valid), 32'hFE);
        chk("bad_blank", 32'(bus.blank), 32'h00);
        chk("bad_err",   32'(err_cnt),   32'd1);
        chk("bad_upd",   32'(upd_cnt),   32'd11);

        repeat (3) smp(3, 8'h99);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            bus.an  = '1;
            bus.seg = i[0] ? 8'h03 : 8'h99;
        end
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            bus.an  = 8'hFC;
            bus.seg = i[0] ? 8'h03 : 8'h99;
        end
        idle(3);
        chk("illegal_hex",   bus.hex,        32'h76543110);
        chk("illegal_valid", 32'(bus.valid), 32'hFE);
        chk("illegal_upd",   32'(upd_cnt),   32'd11);
        push(3, 4'h4, 1'b1, 1'b0);
        smp(3, 8'h99);
        drain();
        chk("resume_hex", bus.hex,      32'h76544110);
        chk("resume_upd", 32'(upd_cnt), 32'd12);

        repeat (3) smp(5, 8'h71);
        @(negedge clk);
        bus.an  = '1;
        bus.seg = 8'hFF;
        rst     = 1'b1;
        exp_s   = '0;
        q.delete();
        @(negedge clk);
        chk("mid_rst_hex",   bus.hex,        32'h0);
        chk("mid_rst_valid", 32'(bus.valid), 32'h0);
        chk("mid_rst_upd",   32'(bus.upd),   32'h0);
        chk("mid_rst_err",   32'(bus.err),   32'h0);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) smp(5, 8'h71);
        idle(4);
        chk("post_rst_nocommit", 32'(upd_cnt), 32'd12);
        push(5, 4'hF, 1'b1, 1'b0);
        smp(5, 8'h71);
        drain();
        chk("post_rst_hex",   bus.hex,        32'h00F00000);
        chk("post_rst_valid", 32'(bus.valid), 32'h20);
        chk("post_rst_upd",   32'(upd_cnt),   32'd13);

        push(1, 4'h1, 1'b1, 1'b0);
        repeat (20) smp(1, 8'h9F);
        drain();
        chk("hold_hex",   bus.hex,        32'h00F00010);
        chk("hold_valid", 32'(bus.valid), 32'h22);
        chk("hold_upd",   32'(upd_cnt),   32'd14);
        chk("final_err",  32'(err_cnt),   32'd1);

        idle(5);
        chk("final_queue", 32'(q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
